// File: rtl/fsm1_pkg.sv
// Shared types and default sizing for the fsm1 read-target slice.
package fsm1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } tgt_state_t;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_ADDR_W      = 4;
    localparam int unsigned DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/fsm1_rd_target_if.sv
// Read handshake bundle between the upstream fsm1 sequencer and the read target.
// FSM1_RD_TARGET_LOAD_EN adds the register-file write port to the bundle.
interface fsm1_rd_target_if
    import fsm1_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              rd;
    logic              ds;
    logic              ws;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [ADDR_W-1:0] addr;
    logic              abort;
`ifdef FSM1_RD_TARGET_LOAD_EN
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output rd, ds, wr_en, wr_addr, wr_data,
                    input  ws, rdata, rvalid, addr, abort);
    modport slave  (input  rd, ds, wr_en, wr_addr, wr_data,
                    output ws, rdata, rvalid, addr, abort);
`else
    modport master (output rd, ds,
                    input  ws, rdata, rvalid, addr, abort);
    modport slave  (input  rd, ds,
                    output ws, rdata, rvalid, addr, abort);
`endif
endinterface

// File: rtl/fsm1_rd_mem.sv
// Small register file with reset pattern mem[i]=i and asynchronous read.
// FSM1_RD_TARGET_LOAD_EN adds a synchronous write port; otherwise the contents are constant logic.
module fsm1_rd_mem
    import fsm1_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
`ifdef FSM1_RD_TARGET_LOAD_EN
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`endif
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_c
);

`ifdef FSM1_RD_TARGET_LOAD_EN
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Reset restores the identity pattern; the old word stays visible on rdata_c until the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rdata_c = mem[raddr];
`else
    assign rdata_c = DATA_W'(raddr);
`endif

endmodule

// File: rtl/fsm1_rd_target.sv
// Read-target responder: holds ws for WAIT_CYCLES, returns one register-file word, advances addr on ds.
// FSM1_RD_TARGET_LOAD_EN exposes the register-file write port through the bus interface.
module fsm1_rd_target
    import fsm1_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input logic             clock,
    input logic             reset_n,
    fsm1_rd_target_if.slave bus
);

    // Zero-wait builds never use the counter but still need a legal width.
    localparam int unsigned CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    tgt_state_t        state;
    tgt_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              ws;
    logic              rvalid;
    logic              abort;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mem_rdata;

    fsm1_rd_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
`ifdef FSM1_RD_TARGET_LOAD_EN
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
`endif
        .raddr   (addr),
        .rdata_c (mem_rdata)
    );

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.rd) begin
                    state_nxt = (WAIT_CYCLES > 0) ? WAIT : READY;
                end
            end
            WAIT: begin
                if (!bus.rd) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (bus.ds) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, wait counter and outputs, all registered from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            ws     <= 1'b0;
            rvalid <= 1'b0;
            abort  <= 1'b0;
            rdata  <= '0;
            addr   <= '0;
        end else begin
            state  <= state_nxt;
            ws     <= (state_nxt == WAIT);
            rvalid <= 1'b0;
            abort  <= 1'b0;

            if (state != WAIT && state_nxt == WAIT) begin
                cnt <= CNT_W'(CNT_LOAD);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            // Capture happens before any same-edge write lands, so a collision returns the old word.
            if (state != READY && state_nxt == READY) begin
                rdata  <= mem_rdata;
                rvalid <= 1'b1;
            end

            if (state == WAIT && !bus.rd) begin
                abort <= 1'b1;
            end

            if (state == READY && bus.ds) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    assign bus.ws     = ws;
    assign bus.rvalid = rvalid;
    assign bus.abort  = abort;
    assign bus.rdata  = rdata;
    assign bus.addr   = addr;

endmodule

// File: tb/tb_fsm1_rd_target.sv
// Directed bench for fsm1_rd_target: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
// Write-port vectors run only when FSM1_RD_TARGET_LOAD_EN is defined.
module tb_fsm1_rd_target;

    logic clock;
    logic reset_n;

    int n_cmp = 0;
    int n_bad = 0;
    logic z_ws_seen = 1'b0;

    fsm1_rd_target_if #(.DATA_W(8), .ADDR_W(4)) bus_a ();
    fsm1_rd_target_if #(.DATA_W(8), .ADDR_W(4)) bus_z ();

    fsm1_rd_target #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(2)) u_dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    fsm1_rd_target #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(0)) u_dut_z (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_z.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus_z.ws === 1'b1) z_ws_seen <= 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One complete access on the WAIT_CYCLES=2 instance, rd held through the wait.
    task automatic access_a(input string tag, input logic [7:0] exp_data);
        bus_a.rd = 1'b1;
        step();
        check_eq({tag, ".ws1"}, 32'(bus_a.ws), 32'd1);
        step();
        check_eq({tag, ".ws2"}, 32'(bus_a.ws), 32'd1);
        step();
        check_eq({tag, ".ws_low"}, 32'(bus_a.ws), 32'd0);
        check_eq({tag, ".rvalid"}, 32'(bus_a.rvalid), 32'd1);
        check_eq({tag, ".rdata"}, 32'(bus_a.rdata), 32'(exp_data));
        bus_a.rd = 1'b0;
        bus_a.ds = 1'b1;
        step();
        bus_a.ds = 1'b0;
        check_eq({tag, ".rvalid_off"}, 32'(bus_a.rvalid), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        bus_a.rd = 1'b0;
        bus_a.ds = 1'b0;
        bus_z.rd = 1'b0;
        bus_z.ds = 1'b0;
`ifdef FSM1_RD_TARGET_LOAD_EN
        bus_a.wr_en   = 1'b0;
        bus_a.wr_addr = '0;
        bus_a.wr_data = '0;
        bus_z.wr_en   = 1'b0;
        bus_z.wr_addr = '0;
        bus_z.wr_data = '0;
`endif
        repeat (2) step();
        check_eq("rst.ws", 32'(bus_a.ws), 32'd0);
        check_eq("rst.rvalid", 32'(bus_a.rvalid), 32'd0);
        check_eq("rst.abort", 32'(bus_a.abort), 32'd0);
        check_eq("rst.rdata", 32'(bus_a.rdata), 32'd0);
        check_eq("rst.addr", 32'(bus_a.addr), 32'd0);
        reset_n = 1'b1;
        step();

        // Zero-wait instance: rvalid in the cycle after rd is sampled.
        bus_z.rd = 1'b1;
        step();
        check_eq("z.rvalid", 32'(bus_z.rvalid), 32'd1);
        check_eq("z.rdata", 32'(bus_z.rdata), 32'd0);
        check_eq("z.ws", 32'(bus_z.ws), 32'd0);
        bus_z.rd = 1'b0;
        bus_z.ds = 1'b1;
        step();
        bus_z.ds = 1'b0;
        check_eq("z.addr", 32'(bus_z.addr), 32'd1);
        check_eq("z.rvalid_off", 32'(bus_z.rvalid), 32'd0);

        // 16 accesses walk the identity pattern and wrap addr; the 17th returns 0x00.
        for (int i = 0; i < 16; i++) begin
            access_a($sformatf("acc%0d", i), 8'(i));
            check_eq($sformatf("acc%0d.addr", i), 32'(bus_a.addr), 32'((i + 1) % 16));
        end
        access_a("acc16", 8'h00);
        check_eq("acc16.addr", 32'(bus_a.addr), 32'd1);

        // Drop rd after one ws cycle.
        bus_a.rd = 1'b1;
        step();
        check_eq("abt.ws", 32'(bus_a.ws), 32'd1);
        bus_a.rd = 1'b0;
        step();
        check_eq("abt.abort", 32'(bus_a.abort), 32'd1);
        check_eq("abt.rvalid", 32'(bus_a.rvalid), 32'd0);
        check_eq("abt.ws_low", 32'(bus_a.ws), 32'd0);
        step();
        check_eq("abt.abort_off", 32'(bus_a.abort), 32'd0);
        check_eq("abt.addr", 32'(bus_a.addr), 32'd1);
        access_a("abt.next", 8'h01);
        check_eq("abt.next_addr", 32'(bus_a.addr), 32'd2);

`ifdef FSM1_RD_TARGET_LOAD_EN
        bus_a.wr_en   = 1'b1;
        bus_a.wr_addr = 4'd2;
        bus_a.wr_data = 8'hA5;
        step();
        bus_a.wr_en = 1'b0;
        access_a("ld.a5", 8'hA5);
        // Write to address 3 on the same edge that enters READY.
        bus_a.rd = 1'b1;
        step();
        step();
        bus_a.wr_en   = 1'b1;
        bus_a.wr_addr = 4'd3;
        bus_a.wr_data = 8'h5A;
        step();
        bus_a.wr_en = 1'b0;
        check_eq("ld.coll_rvalid", 32'(bus_a.rvalid), 32'd1);
        check_eq("ld.coll_rdata", 32'(bus_a.rdata), 32'h03);
        bus_a.rd = 1'b0;
        bus_a.ds = 1'b1;
        step();
        bus_a.ds = 1'b0;
        check_eq("ld.addr", 32'(bus_a.addr), 32'd4);
`endif

        // Asynchronous reset in the middle of WAIT.
        bus_a.rd = 1'b1;
        step();
        check_eq("ar.ws_pre", 32'(bus_a.ws), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("ar.ws", 32'(bus_a.ws), 32'd0);
        check_eq("ar.rvalid", 32'(bus_a.rvalid), 32'd0);
        check_eq("ar.abort", 32'(bus_a.abort), 32'd0);
        check_eq("ar.rdata", 32'(bus_a.rdata), 32'd0);
        check_eq("ar.addr", 32'(bus_a.addr), 32'd0);
        check_eq("ar.z_addr", 32'(bus_z.addr), 32'd0);
        bus_a.rd = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        // Register file back to its reset pattern.
        for (int i = 0; i < 4; i++) begin
            access_a($sformatf("post%0d", i), 8'(i));
        end
        check_eq("post.addr", 32'(bus_a.addr), 32'd4);

        check_eq("z.ws_never", 32'(z_ws_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
